// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default operand width for the shift-subtract divider
package div_pkg;
   localparam int DIV_WIDTH = 32;
   typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, DONE} state_t;
endpackage

// File: rtl/divider_seq_ctrl.sv
// divider_seq_ctrl: sequences load, WIDTH shift-subtract steps and a final right-shift fix-up
module divider_seq_ctrl
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             div_zero,
   output logic             w_ctrl_reg2,
   output logic             w_ctrl_div,
   output logic             reg2_en,
   output logic             SLL_ctrl,
   output logic             SRL_ctrl,
   output logic             busy,
   output logic             rdy,
   output logic             dz_err,
   output logic [CNT_W-1:0] iter_cnt
);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dz_q, dz_d;
   // state, iteration count and divide-by-zero flag registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dz_q    <= dz_d;
      end
   end
   // next-state logic; run is only honoured in IDLE or DONE, never queued while busy
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dz_d    = dz_q;
      case (state_q)
         IDLE: state_d = run ? LOAD : IDLE;
         LOAD: begin
            cnt_d   = '0;
            dz_d    = div_zero;
            state_d = div_zero ? DONE : ITER;
         end
         ITER: begin
            cnt_d   = (cnt_q == CNT_W'(WIDTH)) ? cnt_q : cnt_q + 1'b1;
            state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? FIX : ITER;
         end
         FIX:  state_d = DONE;
         DONE: state_d = run ? LOAD : DONE;
         default: state_d = IDLE;
      endcase
   end
   assign w_ctrl_reg2 = state_q == LOAD;
   assign w_ctrl_div  = state_q == LOAD;
   assign SLL_ctrl    = state_q == ITER;
   assign SRL_ctrl    = state_q == FIX;
   assign busy        = w_ctrl_reg2 | SLL_ctrl | SRL_ctrl;
   assign reg2_en     = busy;
   assign rdy         = state_q == DONE;
   assign dz_err      = dz_q & rdy;
   assign iter_cnt    = cnt_q;
endmodule
